// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider on one datapath.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand multiply and divide-by-zero bypass the iteration phase.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             START,
    input  logic [2:0]       FUNCT3,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t               state, state_nxt;
    logic                 accept, early;
    logic                 a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2:0]           op;
    logic                 sa, sb, bz;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     res_sel;

    // Shift-add step: low half holds the remaining multiplier bits, high half the partial product.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {s, a[WIDTH-1:1]};
    endfunction

    // Restoring step: high half is the partial remainder, low half shifts dividend out and quotient in.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r;
        logic           q;
        r = a[2*WIDTH-1:WIDTH-1];
        q = (r >= {1'b0, d});
        if (q) r = r - {1'b0, d};
        return {r[WIDTH-1:0], a[WIDTH-2:0], q};
    endfunction

    function automatic logic [2*WIDTH-1:0] div_fix(input logic [2*WIDTH-1:0] a,
                                                   input logic neg_r, input logic neg_q);
        logic [WIDTH-1:0] r, q;
        r = a[2*WIDTH-1:WIDTH];
        q = a[WIDTH-1:0];
        if (neg_r) r = -r;
        if (neg_q) q = -q;
        return {r, q};
    endfunction

    always_comb begin
        a_signed = !(FUNCT3 inside {3'b011, 3'b101, 3'b111});
        b_signed = FUNCT3 inside {3'b001, 3'b100, 3'b110};
        a_neg    = a_signed & A[WIDTH-1];
        b_neg    = b_signed & B[WIDTH-1];
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
`ifdef MULDIV_EARLY_OUT_EN
        early    = FUNCT3[2] ? (B == '0) : ((A == '0) || (B == '0));
`else
        early    = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = early ? S_FIX : S_ITER;
            S_ITER:  if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state != S_IDLE);
        accept = (state == S_IDLE) && START;
    end

    // Early-out preloads the accumulator with what the iterations would have produced.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            op   <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            bz   <= 1'b0;
            opnd <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op   <= FUNCT3;
                    sa   <= a_neg;
                    sb   <= b_neg;
                    bz   <= (B == '0);
                    cnt  <= '0;
                    opnd <= FUNCT3[2] ? b_mag : a_mag;
                    if (early)
                        acc <= FUNCT3[2] ? {a_mag, {WIDTH{1'b1}}} : '0;
                    else
                        acc <= {{WIDTH{1'b0}}, (FUNCT3[2] ? a_mag : b_mag)};
                end
                S_ITER: begin
                    acc <= op[2] ? div_step(acc, opnd) : mul_step(acc, opnd);
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (op[2])
                        acc <= div_fix(acc, sa, (sa ^ sb) && !bz);
                    else if (sa ^ sb)
                        acc <= -acc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        res_sel = ((op == 3'b000) || (op[2:1] == 2'b10)) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            DONE   <= 1'b0;
            RESULT <= '0;
            ZERO   <= 1'b1;
        end else begin
            DONE <= (state == S_DONE);
            if (state == S_DONE) begin
                RESULT <= res_sel;
                ZERO   <= (res_sel == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: results, latency, handshake, reset and early-out behaviour.
module tb_alu_muldiv;

    localparam int W   = 32;
    localparam int LAT = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = W + 2;
`endif

    logic         CLK, RST_n, START;
    logic [2:0]   FUNCT3;
    logic [W-1:0] A, B, RESULT;
    logic         BUSY, DONE, ZERO;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
    } exp_t;
    exp_t sbq[$];

    alu_muldiv #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_n(RST_n), .START(START), .FUNCT3(FUNCT3),
        .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] sa64, ua64, sb64, ub64, p;
        sa64 = {{32{a[31]}}, a};
        ua64 = {32'b0, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'b0, b};
        case (f)
            3'd0: begin p = ua64 * ub64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic push_exp(input logic [W-1:0] r);
        exp_t e;
        e.res  = r;
        e.zero = (r == '0);
        sbq.push_back(e);
    endtask

    // Issues one operation, pushes its expectation and waits (bounded) for DONE.
    task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, output int lat, output logic busy0,
                         output logic [W-1:0] res, output logic z);
        push_exp(exp_res);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f; A = a; B = b;
        @(posedge CLK); #1;
        START = 1'b0; A = $urandom; B = $urandom;
        busy0 = BUSY;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) begin lat = n; break; end
        end
        res = RESULT;
        z   = ZERO;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", DONE); end
        tests_run++; if (RESULT !== '0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", RESULT); end
        tests_run++; if (ZERO !== 1'b1) begin tests_failed++; $display("FAIL reset_zero: got %b expected 1", ZERO); end
        @(negedge CLK); RST_n = 1'b1;
        @(posedge CLK); #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got %b expected 0", BUSY); end
    endtask

    task automatic test_mul;
        int lat; logic b0; logic [W-1:0] res; logic z; exp_t e;
        do_op(3'b000, 32'h000000EC, 32'h00000258, 32'h00022920, lat, b0, res, z);
        e = sbq.pop_front();
        tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL mul_result: got %h expected %h", res, e.res); end
        tests_run++; if (z !== e.zero) begin tests_failed++; $display("FAIL mul_zero: got %b expected %b", z, e.zero); end
        tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL mul_latency: got %0d expected %0d", lat, LAT); end
        tests_run++; if (b0 !== 1'b1) begin tests_failed++; $display("FAIL mul_busy_at_accept: got %b expected 1", b0); end
        @(posedge CLK); #1;
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL mul_done_width: got %b expected 0", DONE); end
        tests_run++; if (RESULT !== e.res) begin tests_failed++; $display("FAIL mul_result_hold: got %h expected %h", RESULT, e.res); end
    endtask

    task automatic test_high_half;
        logic [2:0] f [4];
        logic [W-1:0] ex [4];
        int lat; logic b0; logic [W-1:0] res; logic z; exp_t e;
        f  = '{3'b001, 3'b011, 3'b010, 3'b000};
        ex = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
        for (int i = 0; i < 4; i++) begin
            do_op(f[i], 32'hFFFFFFFF, 32'hFFFFFFFF, ex[i], lat, b0, res, z);
            e = sbq.pop_front();
            tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL high_half_%0d result: got %h expected %h", i, res, e.res); end
            tests_run++; if (z !== e.zero) begin tests_failed++; $display("FAIL high_half_%0d zero: got %b expected %b", i, z, e.zero); end
        end
    endtask

    task automatic test_divide;
        logic [2:0] f [8];
        logic [W-1:0] a [8], b [8], ex [8];
        int lat; logic b0; logic [W-1:0] res; logic z; exp_t e;
        f  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b111, 3'b100, 3'b110};
        a  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h64, 32'h64, 32'hFFFFFFF9, 32'h64, 32'h80000000, 32'h80000000};
        b  = '{32'h2, 32'h2, 32'h1A, 32'h1A, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ex = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h3, 32'h16, 32'hFFFFFFFF, 32'h64, 32'h80000000, 32'h0};
        for (int i = 0; i < 8; i++) begin
            do_op(f[i], a[i], b[i], ex[i], lat, b0, res, z);
            e = sbq.pop_front();
            tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL divide_%0d result: got %h expected %h", i, res, e.res); end
            tests_run++; if (z !== e.zero) begin tests_failed++; $display("FAIL divide_%0d zero: got %b expected %b", i, z, e.zero); end
        end
    endtask

    task automatic test_ignore_start;
        int lat; exp_t e;
        push_exp(32'h3);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b101; A = 32'h64; B = 32'h1A;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge CLK);
            if (n == 5 || n == 20) begin
                START = 1'b1; FUNCT3 = 3'b000; A = $urandom; B = $urandom;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            if (DONE === 1'b1) begin lat = n; break; end
        end
        START = 1'b0;
        e = sbq.pop_front();
        tests_run++; if (RESULT !== e.res) begin tests_failed++; $display("FAIL ignore_start_result: got %h expected %h", RESULT, e.res); end
        tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL ignore_start_latency: got %0d expected %0d", lat, LAT); end
        repeat (3) @(posedge CLK);
        #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL ignore_start_idle: got busy %b expected 0", BUSY); end
        tests_run++; if (RESULT !== e.res) begin tests_failed++; $display("FAIL ignore_start_hold: got %h expected %h", RESULT, e.res); end
    endtask

    task automatic test_async_reset;
        int lat; logic b0; logic [W-1:0] res; logic z; exp_t e;
        do_op(3'b000, 32'h3, 32'h5, 32'hF, lat, b0, res, z);
        e = sbq.pop_front();
        tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL pre_reset_result: got %h expected %h", res, e.res); end
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b100; A = 32'h12345678; B = 32'h9;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #3; RST_n = 1'b0; #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL async_reset_busy: got %b expected 0", BUSY); end
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL async_reset_done: got %b expected 0", DONE); end
        tests_run++; if (RESULT !== '0) begin tests_failed++; $display("FAIL async_reset_result: got %h expected 0", RESULT); end
        tests_run++; if (ZERO !== 1'b1) begin tests_failed++; $display("FAIL async_reset_zero: got %b expected 1", ZERO); end
        @(negedge CLK); RST_n = 1'b1;
        @(posedge CLK); #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL after_reset_idle: got busy %b expected 0", BUSY); end
        do_op(3'b000, 32'h000000EC, 32'h00000258, 32'h00022920, lat, b0, res, z);
        e = sbq.pop_front();
        tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL after_reset_result: got %h expected %h", res, e.res); end
        tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, lat; logic b0, b1; logic [W-1:0] res1, res; logic z; exp_t e;
        logic [2:0] f; logic [W-1:0] a, b;
        push_exp(32'h3F);
        push_exp(32'hE);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b000; A = 32'h7; B = 32'h9;
        @(posedge CLK); #1;
        FUNCT3 = 3'b101; A = 32'd100; B = 32'd7;
        lat1 = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) begin lat1 = n; break; end
        end
        res1 = RESULT;
        @(posedge CLK); #1;
        START = 1'b0;
        b1 = BUSY;
        lat2 = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) begin lat2 = n; break; end
        end
        e = sbq.pop_front();
        tests_run++; if (res1 !== e.res) begin tests_failed++; $display("FAIL b2b_first_result: got %h expected %h", res1, e.res); end
        tests_run++; if (lat1 !== LAT) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat1, LAT); end
        e = sbq.pop_front();
        tests_run++; if (RESULT !== e.res) begin tests_failed++; $display("FAIL b2b_second_result: got %h expected %h", RESULT, e.res); end
        tests_run++; if (b1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_accept: got busy %b expected 1", b1); end
        tests_run++; if (lat2 !== LAT) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat2, LAT); end
        for (int i = 0; i < 10; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 3) ? 32'h0 : $urandom >> $urandom_range(0, 28);
            do_op(f, a, b, model(f, a, b), lat, b0, res, z);
            e = sbq.pop_front();
            tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL random_%0d f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, e.res); end
            tests_run++; if (z !== e.zero) begin tests_failed++; $display("FAIL random_%0d zero: got %b expected %b", i, z, e.zero); end
        end
    endtask

    task automatic test_early_out;
        int lat; logic b0; logic [W-1:0] res; logic z; exp_t e;
        do_op(3'b101, 32'h64, 32'h0, 32'hFFFFFFFF, lat, b0, res, z);
        e = sbq.pop_front();
        tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL early_divu_result: got %h expected %h", res, e.res); end
        tests_run++; if (lat !== EARLY_LAT) begin tests_failed++; $display("FAIL early_divu_latency: got %0d expected %0d", lat, EARLY_LAT); end
        do_op(3'b000, 32'h0, 32'h1234, 32'h0, lat, b0, res, z);
        e = sbq.pop_front();
        tests_run++; if (res !== e.res) begin tests_failed++; $display("FAIL early_mul_result: got %h expected %h", res, e.res); end
        tests_run++; if (z !== e.zero) begin tests_failed++; $display("FAIL early_mul_zero: got %b expected %b", z, e.zero); end
        tests_run++; if (lat !== EARLY_LAT) begin tests_failed++; $display("FAIL early_mul_latency: got %0d expected %0d", lat, EARLY_LAT); end
        @(posedge CLK); #1;
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL early_done_width: got %b expected 0", DONE); end
    endtask

    initial begin
        RST_n = 1'b0; START = 1'b0; FUNCT3 = 3'b000; A = '0; B = '0;
        test_reset;
        test_mul;
        test_high_half;
        test_divide;
        test_ignore_start;
        test_async_reset;
        test_back_to_back;
        test_early_out;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
